// File: rtl/vector_exec_scheduler_if.sv
// Bundle of the scheduler's handshake and datapath buses: descriptor issue,
// VRF read/write ports, VFU launch/operand/result port and retire report.
// The master modport is the scheduler; the slave modport is its environment.
interface vector_exec_scheduler_if #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
);
    localparam int VLEN   = VECTOR_SIZE * LEN;
    localparam int DESC_W = 41 + ENTRY_INDEX_SIZE + 2 * LEN;

    logic                      rdy_in;
    logic                      busy;

    logic                      issue_valid;
    logic                      issue_ready;
    logic [DESC_W-1:0]         issue_desc;

    logic                      vrf_rd_en;
    logic [4:0]                vrf_rs1_idx;
    logic [4:0]                vrf_rs2_idx;
    logic [4:0]                vrf_rs3_idx;
    logic [VLEN-1:0]           vrf_vs1;
    logic [VLEN-1:0]           vrf_vs2;
    logic [VLEN-1:0]           vrf_vs3;
    logic [VLEN-1:0]           vrf_v0;

    logic                      vfu_execute;
    logic [2:0]                vfu_vsew;
    logic                      vfu_vm;
    logic [ENTRY_INDEX_SIZE:0] vfu_length;
    logic [5:0]                vfu_funct6;
    logic [2:0]                vfu_alu_signal;
    logic [1:0]                vfu_operand_type;
    logic [4:0]                vfu_ext_type;
    logic [LEN-1:0]            vfu_imm;
    logic [LEN-1:0]            vfu_rs;
    logic [VLEN-1:0]           vfu_vs1;
    logic [VLEN-1:0]           vfu_vs2;
    logic [VLEN-1:0]           vfu_vs3;
    logic [VLEN-1:0]           vfu_mask;
    logic [VLEN-1:0]           vfu_result;
    logic [1:0]                vfu_status;

    logic                      vrf_we;
    logic [4:0]                vrf_wd_idx;
    logic [VLEN-1:0]           vrf_wdata;

    logic                      retire_valid;
    logic [4:0]                retire_vd;

    modport master (
        input  rdy_in, issue_valid, issue_desc,
        input  vrf_vs1, vrf_vs2, vrf_vs3, vrf_v0,
        input  vfu_result, vfu_status,
        output busy, issue_ready,
        output vrf_rd_en, vrf_rs1_idx, vrf_rs2_idx, vrf_rs3_idx,
        output vfu_execute, vfu_vsew, vfu_vm, vfu_length, vfu_funct6,
        output vfu_alu_signal, vfu_operand_type, vfu_ext_type, vfu_imm, vfu_rs,
        output vfu_vs1, vfu_vs2, vfu_vs3, vfu_mask,
        output vrf_we, vrf_wd_idx, vrf_wdata,
        output retire_valid, retire_vd
    );

    modport slave (
        output rdy_in, issue_valid, issue_desc,
        output vrf_vs1, vrf_vs2, vrf_vs3, vrf_v0,
        output vfu_result, vfu_status,
        input  busy, issue_ready,
        input  vrf_rd_en, vrf_rs1_idx, vrf_rs2_idx, vrf_rs3_idx,
        input  vfu_execute, vfu_vsew, vfu_vm, vfu_length, vfu_funct6,
        input  vfu_alu_signal, vfu_operand_type, vfu_ext_type, vfu_imm, vfu_rs,
        input  vfu_vs1, vfu_vs2, vfu_vs3, vfu_mask,
        input  vrf_we, vrf_wd_idx, vrf_wdata,
        input  retire_valid, retire_vd
    );
endinterface

// File: rtl/vector_exec_scheduler.sv
// In-order vector execution scheduler: buffers issued descriptors, reads
// operands from the VRF, launches the VFU with a one-cycle pulse, waits for
// completion, then writes back and retires one instruction at a time.
module vector_exec_scheduler #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int FIFO_DEPTH       = 4,
    parameter int FIFO_INDEX_SIZE  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    vector_exec_scheduler_if.master bus
);
    localparam int VLEN = VECTOR_SIZE * LEN;
    localparam logic [1:0] VFU_WORKING  = 2'b01;
    localparam logic [1:0] VFU_FINISHED = 2'b10;
    localparam logic [FIFO_INDEX_SIZE:0] DEPTH = (FIFO_INDEX_SIZE + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [5:0]                funct6;
        logic [2:0]                alu_signal;
        logic [1:0]                operand_type;
        logic [4:0]                ext_type;
        logic [2:0]                vsew;
        logic                      vm;
        logic [ENTRY_INDEX_SIZE:0] length;
        logic [4:0]                vd;
        logic [4:0]                vs1;
        logic [4:0]                vs2;
        logic [4:0]                vs3;
        logic [LEN-1:0]            imm;
        logic [LEN-1:0]            rs;
    } desc_t;

    typedef enum logic [2:0] {IDLE, READ, LAUNCH, WAIT, WB} state_t;

    state_t                     state, state_nxt;
    desc_t                      fifo_mem [FIFO_DEPTH];
    desc_t                      head_desc;
    logic [FIFO_INDEX_SIZE-1:0] head, tail;
    logic [FIFO_INDEX_SIZE:0]   count;
    logic                       full, empty, push, pop;

    // Current-instruction registers (configuration held from pop to retire)
    logic [5:0]                 funct6_q;
    logic [2:0]                 alu_q;
    logic [1:0]                 optype_q;
    logic [4:0]                 ext_q;
    logic [2:0]                 vsew_q;
    logic                       vm_q;
    logic [ENTRY_INDEX_SIZE:0]  length_q;
    logic [4:0]                 vd_q;
    logic [LEN-1:0]             imm_q;
    logic [LEN-1:0]             rs_q;
    logic                       skip_q;

    logic [VLEN-1:0]            vs1_q, vs2_q, vs3_q, mask_q, wdata_q;

    logic                       rd_en_c, exec_c, we_c, retire_c;
    logic [4:0]                 rs1_c, rs2_c, rs3_c, wd_idx_c, retire_vd_c;

    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign head_desc = fifo_mem[head];
    assign push      = bus.issue_valid && bus.issue_ready;
    // The VFU must be idle before a new instruction leaves the queue.
    assign pop       = (state == IDLE) && bus.rdy_in && !empty
                       && (bus.vfu_status != VFU_WORKING);

    // Descriptor storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= bus.issue_desc;
    end

    // Queue pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the popped descriptor; zero-length entries bypass VRF and VFU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct6_q <= '0; alu_q  <= '0; optype_q <= '0; ext_q <= '0;
            vsew_q   <= '0; vm_q   <= 1'b0; length_q <= '0; vd_q  <= '0;
            imm_q    <= '0; rs_q   <= '0; skip_q   <= 1'b0;
        end else if (pop) begin
            funct6_q <= head_desc.funct6;
            alu_q    <= head_desc.alu_signal;
            optype_q <= head_desc.operand_type;
            ext_q    <= head_desc.ext_type;
            vsew_q   <= head_desc.vsew;
            vm_q     <= head_desc.vm;
            length_q <= head_desc.length;
            vd_q     <= head_desc.vd;
            imm_q    <= head_desc.imm;
            rs_q     <= head_desc.rs;
            skip_q   <= (head_desc.length == '0);
        end
    end

    // Operand capture: VRF data is valid the cycle after the read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs1_q  <= '0;
            vs2_q  <= '0;
            vs3_q  <= '0;
            mask_q <= '0;
        end else if (state == READ) begin
            vs1_q  <= bus.vrf_vs1;
            vs2_q  <= bus.vrf_vs2;
            vs3_q  <= bus.vrf_vs3;
            mask_q <= bus.vrf_v0;
        end
    end

    // Result capture; FINISHED lasts one cycle so rdy_in is not consulted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                  wdata_q <= '0;
        else if (state == WAIT && bus.vfu_status == VFU_FINISHED) wdata_q <= bus.vfu_result;
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt   = state;
        rd_en_c     = 1'b0;
        rs1_c       = '0;
        rs2_c       = '0;
        rs3_c       = '0;
        exec_c      = 1'b0;
        we_c        = 1'b0;
        wd_idx_c    = '0;
        retire_c    = 1'b0;
        retire_vd_c = '0;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (head_desc.length == '0) begin
                        state_nxt = WB;
                    end else begin
                        rd_en_c   = 1'b1;
                        rs1_c     = head_desc.vs1;
                        rs2_c     = head_desc.vs2;
                        rs3_c     = head_desc.vs3;
                        state_nxt = READ;
                    end
                end
            end
            READ: state_nxt = LAUNCH;
            LAUNCH: begin
                if (bus.rdy_in && bus.vfu_status != VFU_WORKING) begin
                    exec_c    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.vfu_status == VFU_FINISHED) state_nxt = WB;
            end
            WB: begin
                we_c        = !skip_q;
                wd_idx_c    = vd_q;
                retire_c    = 1'b1;
                retire_vd_c = vd_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.issue_ready      = !full && bus.rdy_in;
    assign bus.busy             = !empty || (state != IDLE);
    assign bus.vrf_rd_en        = rd_en_c;
    assign bus.vrf_rs1_idx      = rs1_c;
    assign bus.vrf_rs2_idx      = rs2_c;
    assign bus.vrf_rs3_idx      = rs3_c;
    assign bus.vfu_execute      = exec_c;
    assign bus.vfu_vsew         = vsew_q;
    assign bus.vfu_vm           = vm_q;
    assign bus.vfu_length       = length_q;
    assign bus.vfu_funct6       = funct6_q;
    assign bus.vfu_alu_signal   = alu_q;
    assign bus.vfu_operand_type = optype_q;
    assign bus.vfu_ext_type     = ext_q;
    assign bus.vfu_imm          = imm_q;
    assign bus.vfu_rs           = rs_q;
    assign bus.vfu_vs1          = vs1_q;
    assign bus.vfu_vs2          = vs2_q;
    assign bus.vfu_vs3          = vs3_q;
    assign bus.vfu_mask         = mask_q;
    assign bus.vrf_we           = we_c;
    assign bus.vrf_wd_idx       = wd_idx_c;
    assign bus.vrf_wdata        = wdata_q;
    assign bus.retire_valid     = retire_c;
    assign bus.retire_vd        = retire_vd_c;
endmodule

// File: tb/tb_vector_exec_scheduler.sv
// Directed bench for vector_exec_scheduler with small VRF and VFU models.
`timescale 1ns/1ps
module tb_vector_exec_scheduler;
    localparam int LEN              = 32;
    localparam int VECTOR_SIZE      = 8;
    localparam int ENTRY_INDEX_SIZE = 3;
    localparam int FIFO_DEPTH       = 4;
    localparam int FIFO_INDEX_SIZE  = 2;
    localparam int VLEN             = VECTOR_SIZE * LEN;
    localparam int DESC_W           = 41 + ENTRY_INDEX_SIZE + 2 * LEN;
    localparam logic [1:0] NOP = 2'b00, WORKING = 2'b01, FINISHED = 2'b10;
    localparam logic [VLEN-1:0] A5_PAT = {VECTOR_SIZE{32'h0000_00A5}};

    logic clk, rst;
    int   n_checks, n_errors;
    int   vfu_lat, vfu_cnt;
    logic vfu_hold;

    vector_exec_scheduler_if #(.LEN(LEN), .VECTOR_SIZE(VECTOR_SIZE),
                               .ENTRY_INDEX_SIZE(ENTRY_INDEX_SIZE)) bus ();

    vector_exec_scheduler #(.LEN(LEN), .VECTOR_SIZE(VECTOR_SIZE),
                            .ENTRY_INDEX_SIZE(ENTRY_INDEX_SIZE),
                            .FIFO_DEPTH(FIFO_DEPTH),
                            .FIFO_INDEX_SIZE(FIFO_INDEX_SIZE))
        dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] vreg_val(input logic [4:0] idx);
        logic [LEN-1:0] w;
        w = 32'hA000_0000 | {27'h0, idx};
        return {VECTOR_SIZE{w}};
    endfunction

    function automatic logic [VLEN-1:0] exp_result(input logic [4:0] vs1);
        return A5_PAT ^ vreg_val(vs1);
    endfunction

    // funct6=0 (vadd), alu=1, vsew=2 (four-byte), vm=1, vs2=2, vs3=0, imm=0x1234, rs=0x55
    function automatic logic [DESC_W-1:0] make_desc(input logic [4:0] vd, input logic [4:0] vs1,
                                                    input logic [ENTRY_INDEX_SIZE:0] len);
        return {6'd0, 3'd1, 2'd0, 5'd0, 3'd2, 1'b1, len, vd, vs1, 5'd2, 5'd0,
                32'h0000_1234, 32'h0000_0055};
    endfunction

    // VRF read port model: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus.vrf_rd_en) begin
            bus.vrf_vs1 <= vreg_val(bus.vrf_rs1_idx);
            bus.vrf_vs2 <= vreg_val(bus.vrf_rs2_idx);
            bus.vrf_vs3 <= vreg_val(bus.vrf_rs3_idx);
            bus.vrf_v0  <= ~vreg_val(5'd0);
        end
    end

    // VFU model: WORKING for vfu_lat-1 cycles after launch, then FINISHED for one cycle
    always @(posedge clk) begin
        if (rst) begin
            bus.vfu_status <= NOP;
            vfu_cnt        <= 0;
        end else if (vfu_hold) begin
            bus.vfu_status <= WORKING;
            vfu_cnt        <= 0;
        end else if (bus.vfu_execute) begin
            bus.vfu_result <= A5_PAT ^ bus.vfu_vs1;
            bus.vfu_status <= (vfu_lat <= 1) ? FINISHED : WORKING;
            vfu_cnt        <= vfu_lat - 1;
        end else if (bus.vfu_status == WORKING) begin
            if (vfu_cnt <= 1) bus.vfu_status <= (vfu_cnt == 1) ? FINISHED : NOP;
            vfu_cnt <= (vfu_cnt > 0) ? vfu_cnt - 1 : 0;
        end else if (bus.vfu_status == FINISHED) begin
            bus.vfu_status <= NOP;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({bus.vfu_execute, bus.vrf_rd_en, bus.vrf_we, bus.retire_valid} !== 4'b0) begin
            n_errors++; $display("FAIL reset_strobes: got %b want 0000",
                {bus.vfu_execute, bus.vrf_rd_en, bus.vrf_we, bus.retire_valid}); end
        n_checks++; if (bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.vfu_vs1 !== '0 || bus.vrf_wdata !== '0 || bus.vfu_imm !== '0) begin
            n_errors++; $display("FAIL reset_data: vs1=%0h wdata=%0h imm=%0h want 0",
                bus.vfu_vs1, bus.vrf_wdata, bus.vfu_imm); end
        n_checks++; if (bus.issue_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
        bus.rdy_in = 1'b0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_ready_gated: got %b want 0", bus.issue_ready); end
        bus.rdy_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_vadd();
        vfu_lat = 4;
        @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd3, 5'd1, 4'd8); #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin
            n_errors++; $display("FAIL single_ready: got %b want 1", bus.issue_ready); end
        @(negedge clk); bus.issue_valid = 1'b0; #1;
        n_checks++; if (bus.vrf_rd_en !== 1'b1 || bus.vrf_rs1_idx !== 5'd1 || bus.vrf_rs2_idx !== 5'd2) begin
            n_errors++; $display("FAIL single_read: rd_en=%b rs1=%0d rs2=%0d want 1 1 2",
                bus.vrf_rd_en, bus.vrf_rs1_idx, bus.vrf_rs2_idx); end
        @(negedge clk); #1;
        n_checks++; if (bus.vfu_execute !== 1'b0) begin
            n_errors++; $display("FAIL single_early_exec: got %b want 0", bus.vfu_execute); end
        @(negedge clk); #1;
        n_checks++; if (bus.vfu_execute !== 1'b1) begin
            n_errors++; $display("FAIL single_exec: got %b want 1", bus.vfu_execute); end
        n_checks++; if (bus.vfu_vs1 !== vreg_val(5'd1) || bus.vfu_vs2 !== vreg_val(5'd2)
                        || bus.vfu_mask !== ~vreg_val(5'd0)) begin
            n_errors++; $display("FAIL single_operands: vs1=%0h vs2=%0h mask=%0h",
                bus.vfu_vs1, bus.vfu_vs2, bus.vfu_mask); end
        n_checks++; if (bus.vfu_length !== 4'd8 || bus.vfu_vsew !== 3'd2 || bus.vfu_imm !== 32'h1234
                        || bus.vfu_rs !== 32'h55 || bus.vfu_alu_signal !== 3'd1 || bus.vfu_vm !== 1'b1) begin
            n_errors++; $display("FAIL single_cfg: len=%0d vsew=%0d imm=%0h rs=%0h alu=%0d vm=%b",
                bus.vfu_length, bus.vfu_vsew, bus.vfu_imm, bus.vfu_rs, bus.vfu_alu_signal, bus.vfu_vm); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({bus.vfu_execute, bus.vrf_we, bus.retire_valid} !== 3'b000) begin
                n_errors++; $display("FAIL single_wait%0d: exec/we/retire=%b want 000", i,
                    {bus.vfu_execute, bus.vrf_we, bus.retire_valid}); end
        end
        @(negedge clk); #1;
        n_checks++; if (bus.vrf_we !== 1'b1 || bus.vrf_wd_idx !== 5'd3 || bus.vrf_wdata !== exp_result(5'd1)) begin
            n_errors++; $display("FAIL single_wb: we=%b idx=%0d data=%0h want 1 3 %0h",
                bus.vrf_we, bus.vrf_wd_idx, bus.vrf_wdata, exp_result(5'd1)); end
        n_checks++; if (bus.retire_valid !== 1'b1 || bus.retire_vd !== 5'd3) begin
            n_errors++; $display("FAIL single_retire: valid=%b vd=%0d want 1 3",
                bus.retire_valid, bus.retire_vd); end
        @(negedge clk); #1;
        n_checks++; if ({bus.vrf_we, bus.retire_valid, bus.busy} !== 3'b000) begin
            n_errors++; $display("FAIL single_after: we/retire/busy=%b want 000",
                {bus.vrf_we, bus.retire_valid, bus.busy}); end
    endtask

    task automatic test_back_to_back();
        int   nret   = 0;
        int   nexec  = 0;
        logic pushed = 1'b0;
        vfu_lat  = 4;
        vfu_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'(i), 5'(8 + i), 4'd8); #1;
            n_checks++; if (bus.issue_ready !== 1'b1) begin
                n_errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.issue_ready); end
        end
        @(negedge clk); bus.issue_desc = make_desc(5'd5, 5'd13, 4'd8); #1;
        n_checks++; if (bus.issue_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++; $display("FAIL b2b_full: ready=%b busy=%b want 0 1", bus.issue_ready, bus.busy); end
        vfu_hold = 1'b0;
        for (int cyc = 0; cyc < 200 && nret < 5; cyc++) begin
            @(negedge clk);
            if (pushed) bus.issue_valid = 1'b0;
            #1;
            if (bus.issue_valid && bus.issue_ready) pushed = 1'b1;
            if (bus.vfu_execute) begin
                nexec++;
                n_checks++; if (bus.vfu_status === WORKING) begin
                    n_errors++; $display("FAIL b2b_exec_busy: status=%b while executing", bus.vfu_status); end
            end
            if (bus.retire_valid) begin
                nret++;
                n_checks++; if (bus.retire_vd !== 5'(nret) || bus.vrf_we !== 1'b1) begin
                    n_errors++; $display("FAIL b2b_order: vd=%0d we=%b want %0d 1",
                        bus.retire_vd, bus.vrf_we, nret); end
                n_checks++; if (bus.vrf_wdata !== exp_result(5'(8 + nret))) begin
                    n_errors++; $display("FAIL b2b_data%0d: got %0h want %0h", nret,
                        bus.vrf_wdata, exp_result(5'(8 + nret))); end
            end
        end
        bus.issue_valid = 1'b0;
        n_checks++; if (nret != 5 || nexec != 5) begin
            n_errors++; $display("FAIL b2b_count: retires=%0d execs=%0d want 5 5", nret, nexec); end
    endtask

    task automatic test_zero_length();
        @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd7, 5'd1, 4'd0); #1;
        @(negedge clk); bus.issue_valid = 1'b0; #1;
        n_checks++; if (bus.vrf_rd_en !== 1'b0 || bus.retire_valid !== 1'b0) begin
            n_errors++; $display("FAIL zero_pop: rd_en=%b retire=%b want 0 0", bus.vrf_rd_en, bus.retire_valid); end
        @(negedge clk); #1;
        n_checks++; if (bus.retire_valid !== 1'b1 || bus.retire_vd !== 5'd7) begin
            n_errors++; $display("FAIL zero_retire: valid=%b vd=%0d want 1 7", bus.retire_valid, bus.retire_vd); end
        n_checks++; if (bus.vrf_we !== 1'b0 || bus.vfu_execute !== 1'b0) begin
            n_errors++; $display("FAIL zero_nowrite: we=%b exec=%b want 0 0", bus.vrf_we, bus.vfu_execute); end
        @(negedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.vfu_length !== 4'd0) begin
            n_errors++; $display("FAIL zero_idle: busy=%b len=%0d want 0 0", bus.busy, bus.vfu_length); end
    endtask

    task automatic test_launch_hold();
        int nret = 0;
        vfu_lat = 4;
        @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd4, 5'd5, 4'd8);
        @(negedge clk); bus.issue_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.rdy_in = 1'b0; #1;
            n_checks++; if (bus.vfu_execute !== 1'b0 || bus.busy !== 1'b1) begin
                n_errors++; $display("FAIL hold_exec%0d: exec=%b busy=%b want 0 1", i, bus.vfu_execute, bus.busy); end
        end
        @(negedge clk); bus.rdy_in = 1'b1; #1;
        n_checks++; if (bus.vfu_execute !== 1'b1) begin
            n_errors++; $display("FAIL hold_release: exec=%b want 1", bus.vfu_execute); end
        for (int cyc = 0; cyc < 20 && nret == 0; cyc++) begin
            @(negedge clk); #1;
            if (bus.retire_valid) begin
                nret++;
                n_checks++; if (bus.retire_vd !== 5'd4 || bus.vrf_wdata !== exp_result(5'd5)) begin
                    n_errors++; $display("FAIL hold_wb: vd=%0d data=%0h want 4 %0h",
                        bus.retire_vd, bus.vrf_wdata, exp_result(5'd5)); end
            end
        end
        n_checks++; if (nret != 1) begin
            n_errors++; $display("FAIL hold_timeout: retires=%0d want 1", nret); end
    endtask

    task automatic test_finish_rdy_low();
        vfu_lat = 4;
        @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd6, 5'd7, 4'd8);
        @(negedge clk); bus.issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.vfu_execute !== 1'b1) begin
            n_errors++; $display("FAIL fin_exec: exec=%b want 1", bus.vfu_execute); end
        repeat (4) @(negedge clk);
        bus.rdy_in = 1'b0; #1;
        n_checks++; if (bus.vrf_we !== 1'b0 || bus.retire_valid !== 1'b0) begin
            n_errors++; $display("FAIL fin_early: we=%b retire=%b want 0 0", bus.vrf_we, bus.retire_valid); end
        @(negedge clk); #1;
        n_checks++; if (bus.vrf_we !== 1'b1 || bus.vrf_wd_idx !== 5'd6 || bus.vrf_wdata !== exp_result(5'd7)
                        || bus.retire_valid !== 1'b1 || bus.retire_vd !== 5'd6) begin
            n_errors++; $display("FAIL fin_wb: we=%b idx=%0d data=%0h retire=%b vd=%0d want 1 6 %0h 1 6",
                bus.vrf_we, bus.vrf_wd_idx, bus.vrf_wdata, bus.retire_valid, bus.retire_vd, exp_result(5'd7)); end
        bus.rdy_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   nret   = 0;
        logic pushed = 1'b0;
        vfu_lat = 30;
        @(negedge clk); bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd1, 5'd1, 4'd8);
        @(negedge clk); bus.issue_desc = make_desc(5'd2, 5'd2, 4'd8);
        @(negedge clk); bus.issue_desc = make_desc(5'd3, 5'd3, 4'd8);
        @(negedge clk); bus.issue_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        n_checks++; if ({bus.vfu_execute, bus.vrf_rd_en, bus.vrf_we, bus.retire_valid, bus.busy} !== 5'b0) begin
            n_errors++; $display("FAIL rstmid_ctrl: exec/rd/we/retire/busy=%b want 00000",
                {bus.vfu_execute, bus.vrf_rd_en, bus.vrf_we, bus.retire_valid, bus.busy}); end
        n_checks++; if (bus.vfu_vs1 !== '0 || bus.vfu_imm !== '0 || bus.vfu_length !== '0 || bus.vrf_wdata !== '0) begin
            n_errors++; $display("FAIL rstmid_data: vs1=%0h imm=%0h len=%0d wdata=%0h want 0",
                bus.vfu_vs1, bus.vfu_imm, bus.vfu_length, bus.vrf_wdata); end
        @(negedge clk); rst = 1'b0; vfu_lat = 4;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin bus.issue_valid = 1'b1; bus.issue_desc = make_desc(5'd9, 5'd4, 4'd8); end
            else if (pushed) bus.issue_valid = 1'b0;
            #1;
            if (bus.issue_valid && bus.issue_ready) pushed = 1'b1;
            if (bus.retire_valid) begin
                nret++;
                n_checks++; if (bus.retire_vd !== 5'd9 || bus.vrf_wdata !== exp_result(5'd4)) begin
                    n_errors++; $display("FAIL rstmid_fresh: vd=%0d data=%0h want 9 %0h",
                        bus.retire_vd, bus.vrf_wdata, exp_result(5'd4)); end
            end
        end
        bus.issue_valid = 1'b0;
        n_checks++; if (nret != 1 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_count: retires=%0d busy=%b want 1 0", nret, bus.busy); end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        vfu_lat         = 4;
        vfu_hold        = 1'b0;
        bus.rdy_in      = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_desc  = '0;
        test_reset();
        test_single_vadd();
        test_back_to_back();
        test_zero_length();
        test_launch_hold();
        test_finish_rdy_low();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
